// File: rtl/y86_decode_writeback.sv
// SEQ Y86-64 decode + write-back: 15x64 register file, operand read is combinational (zero latency),
// writes commit on the rising edge; no handshake, the stage accepts one instruction every cycle.
module y86_decode_writeback (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Cnd,
    input  logic [3:0]         icode,
    input  logic [3:0]         rA,
    input  logic [3:0]         rB,
    input  logic signed [63:0] valE,
    input  logic signed [63:0] valM,
    output logic signed [63:0] valA,
    output logic signed [63:0] valB,
    output logic signed [63:0] rax,
    output logic signed [63:0] rcx,
    output logic signed [63:0] rdx,
    output logic signed [63:0] rbx,
    output logic signed [63:0] rsp,
    output logic signed [63:0] rbp,
    output logic signed [63:0] rsi,
    output logic signed [63:0] rdi,
    output logic signed [63:0] r8,
    output logic signed [63:0] r9,
    output logic signed [63:0] r10,
    output logic signed [63:0] r11,
    output logic signed [63:0] r12,
    output logic signed [63:0] r13,
    output logic signed [63:0] r14,
    output logic signed [63:0] rnone
);

    localparam logic [3:0] RNONE = 4'd15;
    localparam logic [3:0] RRSP  = 4'd4;

    localparam logic [3:0] I_CMOV  = 4'd2;
    localparam logic [3:0] I_IRMOV = 4'd3;
    localparam logic [3:0] I_RMMOV = 4'd4;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_OPQ   = 4'd6;
    localparam logic [3:0] I_CALL  = 4'd8;
    localparam logic [3:0] I_RET   = 4'd9;
    localparam logic [3:0] I_PUSH  = 4'd10;
    localparam logic [3:0] I_POP   = 4'd11;

    logic [63:0] regs [0:14];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;

        case (icode)
            I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = rA;
            I_RET, I_POP:                   src_a = RRSP;
            default:                        src_a = RNONE;
        endcase

        case (icode)
            I_RMMOV, I_MRMOV, I_OPQ:        src_b = rB;
            I_CALL, I_RET, I_PUSH, I_POP:   src_b = RRSP;
            default:                        src_b = RNONE;
        endcase

        // cmovXX only writes when the condition held
        case (icode)
            I_CMOV:                         dst_e = Cnd ? rB : RNONE;
            I_IRMOV, I_OPQ:                 dst_e = rB;
            I_CALL, I_RET, I_PUSH, I_POP:   dst_e = RRSP;
            default:                        dst_e = RNONE;
        endcase

        case (icode)
            I_MRMOV, I_POP:                 dst_m = rA;
            default:                        dst_m = RNONE;
        endcase
    end

    assign valA = (src_a == RNONE) ? 64'sd0 : regs[src_a];
    assign valB = (src_b == RNONE) ? 64'sd0 : regs[src_b];

    // the M-port write is issued last so it wins on dstE == dstM (popq %rsp)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (dst_e != RNONE) begin
                regs[dst_e] <= valE;
            end
            if (dst_m != RNONE) begin
                regs[dst_m] <= valM;
            end
        end
    end

    assign rax   = regs[0];
    assign rcx   = regs[1];
    assign rdx   = regs[2];
    assign rbx   = regs[3];
    assign rsp   = regs[4];
    assign rbp   = regs[5];
    assign rsi   = regs[6];
    assign rdi   = regs[7];
    assign r8    = regs[8];
    assign r9    = regs[9];
    assign r10   = regs[10];
    assign r11   = regs[11];
    assign r12   = regs[12];
    assign r13   = regs[13];
    assign r14   = regs[14];
    assign rnone = 64'sd0;

endmodule

// File: tb/tb_y86_decode_writeback.sv
// Directed bench for y86_decode_writeback: reference register model checked every cycle,
// plus hand-computed literal checks for each instruction class.
module tb_y86_decode_writeback;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               Cnd = 1'b0;
    logic [3:0]         icode = 4'd1;
    logic [3:0]         rA = 4'd15;
    logic [3:0]         rB = 4'd15;
    logic signed [63:0] valE = '0;
    logic signed [63:0] valM = '0;
    logic signed [63:0] valA, valB;
    logic signed [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
    logic signed [63:0] r8, r9, r10, r11, r12, r13, r14, rnone;

    int errors = 0;
    int checks = 0;
    logic chk_on = 1'b1;

    y86_decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .Cnd(Cnd), .icode(icode), .rA(rA), .rB(rB),
        .valE(valE), .valM(valM), .valA(valA), .valB(valB),
        .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
        .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
        .r12(r12), .r13(r13), .r14(r14), .rnone(rnone)
    );

    always #5 clk = ~clk;

    wire [63:0] dr [15];
    assign dr[0] = rax;  assign dr[1] = rcx;  assign dr[2] = rdx;   assign dr[3] = rbx;
    assign dr[4] = rsp;  assign dr[5] = rbp;  assign dr[6] = rsi;   assign dr[7] = rdi;
    assign dr[8] = r8;   assign dr[9] = r9;   assign dr[10] = r10;  assign dr[11] = r11;
    assign dr[12] = r12; assign dr[13] = r13; assign dr[14] = r14;

    // Reference model: register array plus the ISA's operand/destination rules
    logic [63:0] m_reg [15];
    initial for (int i = 0; i < 15; i++) m_reg[i] = '0;

    function automatic logic [63:0] rd(input logic [3:0] id);
        return (id == 4'd15) ? 64'd0 : m_reg[id];
    endfunction

    function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return a;
        if (ic inside {4'd9, 4'd11}) return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'd4, 4'd5, 4'd6}) return b;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'd15;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_reg[i] = '0;
        end else begin
            logic [3:0] de, dm;
            de = 4'd15;
            dm = 4'd15;
            if (icode == 4'd2 && Cnd) de = rB;
            if (icode inside {4'd3, 4'd6}) de = rB;
            if (icode inside {4'd8, 4'd9, 4'd10, 4'd11}) de = 4'd4;
            if (icode inside {4'd5, 4'd11}) dm = rA;
            if (de != 4'd15) m_reg[de] = valE;
            if (dm != 4'd15) m_reg[dm] = valM;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare: every negedge, whole register file and operands vs the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 15; i++) chk($sformatf("reg%0d", i), dr[i], m_reg[i]);
            chk("rnone", rnone, 64'd0);
            chk("valA", valA, rd(m_srca(icode, rA)));
            chk("valB", valB, rd(m_srcb(icode, rB)));
        end
    end

    // Inputs change 2 time units after a rising edge; the next edge commits them
    task automatic apply(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] e, input logic [63:0] m, input logic c);
        @(posedge clk);
        #2;
        icode = ic; rA = a; rB = b; valE = e; valM = m; Cnd = c;
    endtask

    initial begin
        #2;
        chk("reset_rax", rax, 64'd0);
        chk("reset_rsp", rsp, 64'd0);
        #10 rst_n = 1'b1;

        // OPq
        apply(4'd3, 4'd15, 4'd2, 64'd10, 64'd0, 1'b0);
        apply(4'd3, 4'd15, 4'd3, 64'd20, 64'd0, 1'b0);
        apply(4'd6, 4'd2, 4'd3, 64'd2, 64'd3, 1'b0);
        #1 chk("opq_valA", valA, 64'd10);
        chk("opq_valB", valB, 64'd20);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("opq_rbx", rbx, 64'd2);
        chk("opq_rdx", rdx, 64'd10);

        // cmovXX
        apply(4'd3, 4'd15, 4'd7, 64'd77, 64'd0, 1'b0);
        apply(4'd2, 4'd6, 4'd7, 64'd6, 64'd0, 1'b0);
        #1 chk("cmov0_valB", valB, 64'd0);
        apply(4'd2, 4'd6, 4'd7, 64'd6, 64'd0, 1'b1);
        #1 chk("cmov0_rdi", rdi, 64'd77);
        chk("cmov1_valB", valB, 64'd0);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("cmov1_rdi", rdi, 64'd6);

        // popq %rsp
        apply(4'd3, 4'd15, 4'd4, 64'd100, 64'd0, 1'b0);
        apply(4'd11, 4'd4, 4'd15, 64'd4, 64'd5, 1'b0);
        #1 chk("pop_valA", valA, 64'd100);
        chk("pop_valB", valB, 64'd100);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("pop_rsp", rsp, 64'd5);

        // pushq / call / ret
        apply(4'd3, 4'd15, 4'd8, 64'd55, 64'd0, 1'b0);
        apply(4'd10, 4'd8, 4'd15, 64'd8, 64'd0, 1'b0);
        #1 chk("push_valA", valA, 64'd55);
        chk("push_valB", valB, 64'd5);
        apply(4'd8, 4'd15, 4'd15, 64'd7, 64'd0, 1'b0);
        #1 chk("push_rsp", rsp, 64'd8);
        chk("call_valA", valA, 64'd0);
        apply(4'd9, 4'd15, 4'd15, 64'd1, 64'd0, 1'b0);
        #1 chk("call_rsp", rsp, 64'd7);
        chk("ret_valA", valA, 64'd7);
        chk("ret_valB", valB, 64'd7);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("ret_rsp", rsp, 64'd1);

        // full-width value
        apply(4'd3, 4'd15, 4'd9, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0);
        apply(4'd6, 4'd9, 4'd2, 64'h8000_0000_0000_0001, 64'd0, 1'b0);
        #1 chk("wide_valA", valA, 64'hDEAD_BEEF_0123_4567);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("wide_rdx", rdx, 64'h8000_0000_0000_0001);
        apply(4'd3, 4'd15, 4'd2, 64'd10, 64'd0, 1'b0);

        // loads and immediates
        apply(4'd3, 4'd15, 4'd12, 64'd300, 64'd0, 1'b0);
        apply(4'd5, 4'd13, 4'd12, 64'd0, 64'd12, 1'b0);
        #1 chk("mrm_valA", valA, 64'd0);
        chk("mrm_valB", valB, 64'd300);
        apply(4'd4, 4'd14, 4'd10, 64'd99, 64'd98, 1'b0);
        #1 chk("mrm_r13", r13, 64'd12);
        apply(4'd3, 4'd15, 4'd11, 64'd13, 64'd0, 1'b0);
        #1 chk("rmm_r10", r10, 64'd0);
        chk("rmm_r14", r14, 64'd0);
        chk("irm_valA", valA, 64'd0);
        chk("irm_valB", valB, 64'd0);
        apply(4'd0, 4'd2, 4'd3, 64'd500, 64'd600, 1'b1);
        #1 chk("irm_r11", r11, 64'd13);
        apply(4'd1, 4'd2, 4'd3, 64'd500, 64'd600, 1'b1);
        apply(4'd7, 4'd2, 4'd3, 64'd500, 64'd600, 1'b1);
        apply(4'd12, 4'd2, 4'd3, 64'd500, 64'd600, 1'b1);
        apply(4'd15, 4'd4, 4'd4, 64'd500, 64'd600, 1'b1);
        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        #1 chk("nowr_rdx", rdx, 64'd10);
        chk("nowr_rbx", rbx, 64'd2);
        chk("nowr_rsp", rsp, 64'd1);

        // reset mid-cycle with a pending OPq write, held across an edge
        apply(4'd6, 4'd2, 4'd3, 64'd2, 64'd3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) chk($sformatf("rst_reg%0d", i), dr[i], 64'd0);
        chk("rst_valA", valA, 64'd0);
        chk("rst_valB", valB, 64'd0);
        @(posedge clk);
        #1 chk("rst_hold_rbx", rbx, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_rbx", rbx, 64'd2);
        chk("post_rst_rdx", rdx, 64'd0);

        apply(4'd1, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        #1 chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
